// File: rtl/round_timer_ctrl_if.sv
// Command/status bundle between the game FSM and the round timer.
// The game FSM drives commands (master); the timer reports status (slave).
interface round_timer_ctrl_if;
    logic       start;
    logic [7:0] load_secs;
    logic       pause;
    logic       abort;
    logic [7:0] secs_left;
    logic       running;
    logic       paused;
    logic       expired;
    logic       tick;
    logic       timeout;
    logic       warn;
    logic       blink;

    modport master (
        output start, load_secs, pause, abort,
        input  secs_left, running, paused, expired,
        input  tick, timeout, warn, blink
    );

    modport slave (
        input  start, load_secs, pause, abort,
        output secs_left, running, paused, expired,
        output tick, timeout, warn, blink
    );
endinterface

// File: rtl/round_timer_ctrl.sv
// Round countdown controller: prescaler, IDLE/RUN/PAUSE/EXPIRED sequencing,
// seconds countdown, warning flag, timeout pulse and expired blink.
module round_timer_ctrl #(
    parameter int TICK_CYCLES = 100000000,
    parameter int WARN_SECS   = 5
) (
    input logic              clk_in,
    input logic              rst,
    round_timer_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_EXP
    } state_e;

    localparam logic [27:0] TERM     = 28'(TICK_CYCLES - 1);
    localparam logic [7:0]  WARN_LIM = 8'(WARN_SECS);

    state_e      state_q, state_d;
    logic [27:0] cnt_q, cnt_d;
    logic [7:0]  secs_q, secs_d;
    logic        running_q, running_d;
    logic        paused_q, paused_d;
    logic        expired_q, expired_d;
    logic        tick_q, tick_d;
    logic        timeout_q, timeout_d;
    logic        warn_q, warn_d;
    logic        blink_q, blink_d;

    logic start_ok;
    logic pause_ok;
    logic term;
    logic last_sec;

    assign start_ok = bus.start && (bus.load_secs != 8'd0);
    assign pause_ok = bus.pause &&
                      (state_q == S_RUN || state_q == S_PAUSE);
    assign term     = (cnt_q == TERM);
    assign last_sec = (secs_q <= 8'd1);

    // State register
    always_ff @(posedge clk_in) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state: abort > start > pause > terminal count
    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = S_IDLE;
        end else if (start_ok) begin
            state_d = S_RUN;
        end else if (pause_ok) begin
            state_d = (state_q == S_RUN) ? S_PAUSE : S_RUN;
        end else if (state_q == S_RUN && term && last_sec) begin
            state_d = S_EXP;
        end
    end

    // Output/datapath: prescaler, countdown, pulses and flags
    always_comb begin
        cnt_d     = cnt_q;
        secs_d    = secs_q;
        blink_d   = blink_q;
        tick_d    = 1'b0;
        timeout_d = 1'b0;
        if (bus.abort) begin
            cnt_d   = '0;
            secs_d  = '0;
            blink_d = 1'b0;
        end else if (start_ok) begin
            cnt_d   = '0;
            secs_d  = bus.load_secs;
            blink_d = 1'b0;
        end else if (pause_ok) begin
            cnt_d = cnt_q;
        end else if (state_q == S_RUN) begin
            if (term) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                if (secs_q != 8'd0) secs_d = secs_q - 8'd1;
                timeout_d = last_sec;
            end else begin
                cnt_d = cnt_q + 28'd1;
            end
        end else if (state_q == S_EXP) begin
            if (term) begin
                cnt_d   = '0;
                blink_d = ~blink_q;
            end else begin
                cnt_d = cnt_q + 28'd1;
            end
        end
        running_d = (state_d == S_RUN);
        paused_d  = (state_d == S_PAUSE);
        expired_d = (state_d == S_EXP);
        warn_d    = (running_d || paused_d) && (secs_d <= WARN_LIM);
    end

    // Registered datapath and outputs
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            cnt_q     <= '0;
            secs_q    <= '0;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
            expired_q <= 1'b0;
            tick_q    <= 1'b0;
            timeout_q <= 1'b0;
            warn_q    <= 1'b0;
            blink_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            secs_q    <= secs_d;
            running_q <= running_d;
            paused_q  <= paused_d;
            expired_q <= expired_d;
            tick_q    <= tick_d;
            timeout_q <= timeout_d;
            warn_q    <= warn_d;
            blink_q   <= blink_d;
        end
    end

    assign bus.secs_left = secs_q;
    assign bus.running   = running_q;
    assign bus.paused    = paused_q;
    assign bus.expired   = expired_q;
    assign bus.tick      = tick_q;
    assign bus.timeout   = timeout_q;
    assign bus.warn      = warn_q;
    assign bus.blink     = blink_q;
endmodule

// File: tb/tb_round_timer_ctrl.sv
// Bench for round_timer_ctrl: directed round scenarios plus random command
// traffic, every cycle compared against a cycle-level behavioural model.
module tb_round_timer_ctrl;
    localparam int TICKS = 4;
    localparam int WARN  = 2;

    logic clk_in;
    logic rst;
    round_timer_ctrl_if bus_if ();

    round_timer_ctrl #(
        .TICK_CYCLES(TICKS),
        .WARN_SECS  (WARN)
    ) dut (
        .clk_in(clk_in),
        .rst   (rst),
        .bus   (bus_if)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int total = 0;
    int bad   = 0;

    // Reference model: phase, cycles elapsed toward the next tick, seconds
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;
    int m_mode    = M_IDLE;
    int m_elapsed = 0;
    int m_secs    = 0;
    bit m_blink   = 0;
    bit m_tick    = 0;
    bit m_tmo     = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        m_tick = 0;
        m_tmo  = 0;
        if (!rst || bus_if.abort) begin
            m_mode = M_IDLE; m_elapsed = 0; m_secs = 0; m_blink = 0;
        end else if (bus_if.start && bus_if.load_secs != 0) begin
            m_mode = M_RUN; m_elapsed = 0; m_blink = 0;
            m_secs = int'(bus_if.load_secs);
        end else if (bus_if.pause && m_mode == M_RUN) begin
            m_mode = M_PAUSE;
        end else if (bus_if.pause && m_mode == M_PAUSE) begin
            m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            m_elapsed++;
            if (m_elapsed == TICKS) begin
                m_elapsed = 0;
                m_tick = 1;
                m_secs = m_secs - 1;
                if (m_secs == 0) begin
                    m_tmo = 1;
                    m_mode = M_EXP;
                end
            end
        end else if (m_mode == M_EXP) begin
            m_elapsed++;
            if (m_elapsed == TICKS) begin
                m_elapsed = 0;
                m_blink = !m_blink;
            end
        end
    endtask

    // One clock: advance DUT and model together, then compare every output
    task automatic step();
        bit live;
        @(posedge clk_in);
        model_step();
        #1;
        live = (m_mode == M_RUN || m_mode == M_PAUSE);
        chk("secs_left", bus_if.secs_left, m_secs);
        chk("running", bus_if.running, m_mode == M_RUN);
        chk("paused", bus_if.paused, m_mode == M_PAUSE);
        chk("expired", bus_if.expired, m_mode == M_EXP);
        chk("tick", bus_if.tick, m_tick);
        chk("timeout", bus_if.timeout, m_tmo);
        chk("warn", bus_if.warn, live && m_secs <= WARN);
        chk("blink", bus_if.blink, m_blink);
    endtask

    task automatic idle_in();
        bus_if.start = 0;
        bus_if.pause = 0;
        bus_if.abort = 0;
    endtask

    task automatic run(input int n);
        idle_in();
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_start(input logic [7:0] secs);
        bus_if.start = 1;
        bus_if.load_secs = secs;
        step();
        idle_in();
    endtask

    task automatic do_pause();
        bus_if.pause = 1;
        step();
        idle_in();
    endtask

    initial begin
        rst = 0;
        bus_if.start = 1;
        bus_if.load_secs = 8'd9;
        bus_if.pause = 0;
        bus_if.abort = 0;

        // 1: reset dominates a start request
        step();
        chk("rst_running", bus_if.running, 0);
        chk("rst_secs", bus_if.secs_left, 0);
        step();
        rst = 1;
        run(3);
        chk("post_rst_idle", bus_if.running | bus_if.expired, 0);

        // 2: nominal countdown from 3
        do_start(8'd3);
        chk("nom_running", bus_if.running, 1);
        chk("nom_secs", bus_if.secs_left, 3);
        chk("nom_warn", bus_if.warn, 0);
        run(3);
        chk("nom_no_tick", bus_if.tick, 0);
        run(1);
        chk("nom_tick1", bus_if.tick, 1);
        chk("nom_secs2", bus_if.secs_left, 2);
        chk("nom_warn2", bus_if.warn, 1);
        run(4);
        chk("nom_secs1", bus_if.secs_left, 1);
        run(4);
        chk("nom_tick3", bus_if.tick, 1);
        chk("nom_timeout", bus_if.timeout, 1);
        chk("nom_expired", bus_if.expired, 1);
        chk("nom_not_run", bus_if.running, 0);
        run(1);
        chk("nom_pulse_len", bus_if.timeout, 0);

        // 3: pause and resume, 2 RUN cycles counted before the pause
        do_start(8'd2);
        run(2);
        do_pause();
        chk("pz_paused", bus_if.paused, 1);
        run(10);
        chk("pz_secs_hold", bus_if.secs_left, 2);
        do_pause();
        chk("pz_resumed", bus_if.running, 1);
        run(1);
        chk("pz_no_tick_yet", bus_if.tick, 0);
        run(1);
        chk("pz_tick", bus_if.tick, 1);
        chk("pz_secs1", bus_if.secs_left, 1);

        // 4: simultaneous commands
        bus_if.abort = 1;
        do_start(8'd6);
        chk("ab_idle", bus_if.running, 0);
        chk("ab_secs", bus_if.secs_left, 0);
        do_start(8'd5);
        run(1);
        do_pause();
        bus_if.pause = 1;
        do_start(8'd7);
        chk("sp_running", bus_if.running, 1);
        chk("sp_secs", bus_if.secs_left, 7);
        run(3);
        chk("sp_no_tick", bus_if.tick, 0);
        run(1);
        chk("sp_tick", bus_if.tick, 1);
        bus_if.abort = 1;
        step();
        do_pause();
        chk("pz_idle_ignored", bus_if.paused, 0);
        do_start(8'd1);
        run(4);
        do_pause();
        chk("pz_exp_ignored", bus_if.expired, 1);

        // 5: reset mid-count (secs_left=5, cnt=2)
        do_start(8'd5);
        run(2);
        rst = 0;
        step();
        chk("mid_rst_secs", bus_if.secs_left, 0);
        chk("mid_rst_run", bus_if.running, 0);
        rst = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("mid_rst_no_tick", bus_if.tick, 0);
        end

        // 6: expired blink, zero-length start ignored, restart
        do_start(8'd1);
        run(4);
        chk("ex_entry_blink", bus_if.blink, 0);
        run(4);
        chk("ex_blink1", bus_if.blink, 1);
        run(4);
        chk("ex_blink0", bus_if.blink, 0);
        do_start(8'd0);
        chk("ex_zero_start", bus_if.expired, 1);
        do_start(8'd1);
        chk("ex_restart_run", bus_if.running, 1);
        chk("ex_restart_blink", bus_if.blink, 0);
        run(4);
        chk("ex_restart_tmo", bus_if.timeout, 1);

        // Random command traffic
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 199) != 0);
            bus_if.start = ($urandom_range(0, 29) == 0);
            bus_if.load_secs = 8'($urandom_range(0, 6));
            bus_if.pause = ($urandom_range(0, 14) == 0);
            bus_if.abort = ($urandom_range(0, 79) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/round_timer_ctrl.md
Name: round_timer_ctrl

Overview:
- Round countdown controller for the guessing game.
- Owns the free-running prescaler that turns the board clock into a 1-per-TICK_CYCLES "second" tick.
- Sequences the prescaler through idle, run, pause and expired phases, and counts down the round time loaded by the game FSM.
- Drives the display/LED logic with seconds remaining, a warning flag, a timeout pulse and an expired-blink signal.

Parameters:
- TICK_CYCLES, 100000000: clk_in cycles per tick (1 s at 100 MHz). Legal range 2..2^28-1. Prescaler is 28 bits wide.
- WARN_SECS, 5: warn is asserted when secs_left is at or below this value while RUN or PAUSE.

Ports:
- clk_in  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk_in.
- start  in  1  level-sampled strobe: load load_secs and begin countdown.
- load_secs  in  8  round length in ticks; sampled only when start is accepted.
- pause  in  1  strobe: toggles between RUN and PAUSE.
- abort  in  1  strobe: return to IDLE.
- secs_left  out  8  remaining ticks.
- running  out  1  state==RUN.
- paused  out  1  state==PAUSE.
- expired  out  1  state==EXPIRED.
- tick  out  1  one-cycle pulse per elapsed tick (RUN only).
- timeout  out  1  one-cycle pulse when the countdown reaches 0.
- warn  out  1  low-time warning.
- blink  out  1  square wave in EXPIRED, 0 elsewhere.

Behaviour:
- All outputs are registered.
- Reset (rst==0 at an edge), on the same edge:
  - state=IDLE, prescaler cnt=0, secs_left=0.
  - running, paused, expired, tick, timeout, warn and blink all 0.
  - This applies from any state, including mid-count.
- States: IDLE, RUN, PAUSE, EXPIRED.
- Command priority each cycle: abort > start > pause > prescaler terminal count. Lower-priority commands in the same cycle are dropped, not queued.
- abort: any state -> IDLE; cnt=0, secs_left=0, blink=0.
- start:
  - Accepted in any state when load_secs != 0: secs_left=load_secs, cnt=0, state=RUN. This includes a restart from RUN or PAUSE.
  - start with load_secs==0 is ignored; state and outputs are unchanged.
- pause: RUN -> PAUSE, or PAUSE -> RUN. Ignored in IDLE and EXPIRED.
- Prescaler in RUN:
  - cnt increments each cycle.
  - At the edge where cnt==TICK_CYCLES-1: cnt=0, secs_left decrements, tick=1 for the following cycle.
  - Each tick therefore follows exactly TICK_CYCLES RUN cycles.
- Prescaler in PAUSE: cnt and secs_left hold, and no tick is issued. Cycles spent in PAUSE do not count toward the next tick.
- Expiry:
  - When the terminal count occurs with secs_left==1: secs_left becomes 0, state becomes EXPIRED, and tick and timeout are both 1 in the same following cycle.
  - secs_left never wraps below 0.
- EXPIRED:
  - The prescaler keeps running.
  - blink starts at 0 on entry and toggles at every terminal count.
  - No tick is issued.
  - secs_left stays 0 until start or abort.
- warn = (state is RUN or PAUSE) and secs_left <= WARN_SECS, registered with secs_left. warn is 0 in IDLE and EXPIRED.
- running, paused and expired are mutually exclusive and update on the same edge as the state.
- Pulses (tick, timeout) last exactly one cycle and are never asserted in IDLE or PAUSE.

Test Plan (TICK_CYCLES=4, WARN_SECS=2):
1. Reset:
   - Stimulus: hold rst=0 for 2 cycles while start=1, load_secs=9.
   - Required: after the first edge, all outputs are 0 and the state is IDLE. Release rst: outputs stay 0 until a start.
2. Nominal countdown:
   - Stimulus: start=1 for one cycle with load_secs=3.
   - Required: next cycle running=1, secs_left=3, warn=0.
   - tick pulses 4, 8 and 12 cycles later, with secs_left 2 (warn=1), 1, 0.
   - timeout=1 and tick=1 together on the third pulse; expired=1, running=0.
3. Pause and resume:
   - Stimulus: load_secs=2; pause after 2 RUN cycles; hold 10 cycles; pause again.
   - Required: paused=1 with no tick during the hold. The first tick arrives exactly 2 RUN cycles after resume, and secs_left is unchanged during the pause.
4. Simultaneous commands:
   - abort+start in RUN -> IDLE, secs_left=0.
   - start+pause in PAUSE with load_secs=7 -> RUN, secs_left=7, cnt restarted.
   - pause in IDLE and in EXPIRED -> ignored.
5. Reset mid-operation:
   - Stimulus: rst=0 for one cycle while RUN with secs_left=5 and cnt=2.
   - Required: next cycle IDLE, all outputs 0, and no residual tick after reset is released.
6. Expired behaviour:
   - In EXPIRED, blink toggles every 4 cycles (0 on entry).
   - start with load_secs=0 is ignored (expired stays 1).
   - start with load_secs=1 gives RUN with blink=0, then timeout 4 cycles later.
